// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the signed ALU comparator: loads A then B from the switch bank, then captures a>=b.
// Latency: a/b update the edge after the load edge is sampled; res_ge/res_valid update one edge later.
// No backpressure: one load edge per press, and edges arriving in the compare cycle are dropped.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   sw         operand value from switch bank (W bits)
//   btn_load   load button level (debounced/synchronised upstream)
//   btn_clr    synchronous clear, active-high; preserves cmp_count
//   ge_in      comparator result, 1 when signed a >= signed b
//   a, b       registered operands driven to the comparator
//   stage      FSM state code: 0=S_A 1=S_B 2=S_CMP 3=S_SHOW
//   res_valid  res_ge holds the result for the current a/b
//   res_ge     captured comparison result
//   cmp_count  completed comparisons, wraps mod 2^CNT_W
module alu_operand_sequencer #(
  parameter int W     = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     sw,
  input  logic             btn_load,
  input  logic             btn_clr,
  input  logic             ge_in,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [1:0]       stage,
  output logic             res_valid,
  output logic             res_ge,
  output logic [CNT_W-1:0] cmp_count
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_CMP  = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_res_valid;
  logic             r_res_ge;
  logic [CNT_W-1:0] r_cmp_count;
  // Resets to 1 so a button held through reset release does not look like a fresh press.
  logic             r_btn_q;

  state_t           w_state_nxt;
  logic [W-1:0]     w_a_nxt;
  logic [W-1:0]     w_b_nxt;
  logic             w_res_valid_nxt;
  logic             w_res_ge_nxt;
  logic [CNT_W-1:0] w_cmp_count_nxt;
  logic             w_load_e;

  assign w_load_e = btn_load & ~r_btn_q;

  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_res_valid_nxt = r_res_valid;
    w_res_ge_nxt    = r_res_ge;
    w_cmp_count_nxt = r_cmp_count;

    if (btn_clr) begin
      // Clear wins over a coincident load edge; the comparison counter survives.
      w_state_nxt     = S_A;
      w_a_nxt         = '0;
      w_b_nxt         = '0;
      w_res_valid_nxt = 1'b0;
      w_res_ge_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_A: begin
          if (w_load_e) begin
            w_a_nxt     = sw;
            w_state_nxt = S_B;
          end
        end
        S_B: begin
          if (w_load_e) begin
            w_b_nxt     = sw;
            w_state_nxt = S_CMP;
          end
        end
        S_CMP: begin
          // Comparator has had a full cycle to settle on the new b.
          w_res_ge_nxt    = ge_in;
          w_res_valid_nxt = 1'b1;
          w_cmp_count_nxt = r_cmp_count + CNT_W'(1);
          w_state_nxt     = S_SHOW;
        end
        S_SHOW: begin
          // A press here starts the next pair directly with operand A.
          if (w_load_e) begin
            w_a_nxt         = sw;
            w_res_valid_nxt = 1'b0;
            w_state_nxt     = S_B;
          end
        end
        default: w_state_nxt = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_A;
      r_a         <= '0;
      r_b         <= '0;
      r_res_valid <= 1'b0;
      r_res_ge    <= 1'b0;
      r_cmp_count <= '0;
      r_btn_q     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_ge    <= w_res_ge_nxt;
      r_cmp_count <= w_cmp_count_nxt;
      r_btn_q     <= btn_load;
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign stage     = r_state;
  assign res_valid = r_res_valid;
  assign res_ge    = r_res_ge;
  assign cmp_count = r_cmp_count;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer paired with a behavioural 6-bit signed comparator.
module tb_alu_operand_sequencer;

  logic       clk;
  logic       reset;
  logic [5:0] sw;
  logic       btn_load;
  logic       btn_clr;
  logic       ge_in;
  logic [5:0] a;
  logic [5:0] b;
  logic [1:0] stage;
  logic       res_valid;
  logic       res_ge;
  logic [7:0] cmp_count;

  int checks;
  int failures;
  logic [7:0] exp_cnt;

  alu_operand_sequencer #(.W(6), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn_load  (btn_load),
    .btn_clr   (btn_clr),
    .ge_in     (ge_in),
    .a         (a),
    .b         (b),
    .stage     (stage),
    .res_valid (res_valid),
    .res_ge    (res_ge),
    .cmp_count (cmp_count)
  );

  // The comparator the sequencer feeds.
  assign ge_in = ($signed(a) >= $signed(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One-cycle press followed by one released cycle; called and returns on a negedge.
  task automatic press(input logic [5:0] v);
    sw       = v;
    btn_load = 1'b1;
    @(negedge clk);
    btn_load = 1'b0;
    @(negedge clk);
  endtask

  // Full A/B pair; returns in S_SHOW with the result captured.
  task automatic run_pair(input string tag, input logic [5:0] va, input logic [5:0] vb,
                          input logic exp_ge);
    press(va);
    press(vb);
    exp_cnt = exp_cnt + 8'd1;
    chk({tag, "_ge"},    {31'd0, res_ge},    {31'd0, exp_ge});
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_cnt"},   {24'd0, cmp_count}, {24'd0, exp_cnt});
  endtask

  initial begin
    logic [5:0] va;
    logic [5:0] vb;
    logic       eg;
    checks   = 0;
    failures = 0;
    exp_cnt  = 8'd0;
    reset    = 1'b1;
    sw       = 6'd0;
    btn_load = 1'b0;
    btn_clr  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stage", {30'd0, stage}, 32'd0);
    chk("rst_a", {26'd0, a}, 32'd0);
    chk("rst_b", {26'd0, b}, 32'd0);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_ge", {31'd0, res_ge}, 32'd0);
    chk("rst_cnt", {24'd0, cmp_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic 5 vs 3 with per-cycle visibility of S_CMP
    press(6'd5);
    chk("basic_a", {26'd0, a}, 32'd5);
    chk("basic_stage_b", {30'd0, stage}, 32'd1);
    sw = 6'd3; btn_load = 1'b1;
    @(negedge clk);
    chk("basic_b", {26'd0, b}, 32'd3);
    chk("basic_stage_cmp", {30'd0, stage}, 32'd2);
    chk("basic_valid_pre", {31'd0, res_valid}, 32'd0);
    btn_load = 1'b0;
    @(negedge clk);
    exp_cnt = 8'd1;
    chk("basic_stage_show", {30'd0, stage}, 32'd3);
    chk("basic_valid", {31'd0, res_valid}, 32'd1);
    chk("basic_ge", {31'd0, res_ge}, 32'd1);
    chk("basic_cnt", {24'd0, cmp_count}, 32'd1);

    // Signed corner cases
    run_pair("neg1_vs_1", 6'h3F, 6'h01, 1'b0);
    run_pair("max_vs_min", 6'h1F, 6'h20, 1'b1);
    run_pair("min_eq_min", 6'h20, 6'h20, 1'b1);

    // S_SHOW reload
    press(6'd7);
    chk("reload_a", {26'd0, a}, 32'd7);
    chk("reload_valid", {31'd0, res_valid}, 32'd0);
    chk("reload_stage", {30'd0, stage}, 32'd1);

    // Button held through B load and S_CMP: no extra load in S_CMP or S_SHOW
    sw = 6'd2; btn_load = 1'b1;
    @(negedge clk);
    sw = 6'd12;
    repeat (3) @(negedge clk);
    btn_load = 1'b0;
    @(negedge clk);
    exp_cnt = exp_cnt + 8'd1;
    chk("cmp_press_stage", {30'd0, stage}, 32'd3);
    chk("cmp_press_a", {26'd0, a}, 32'd7);
    chk("cmp_press_b", {26'd0, b}, 32'd2);
    chk("cmp_press_ge", {31'd0, res_ge}, 32'd1);
    chk("cmp_press_cnt", {24'd0, cmp_count}, {24'd0, exp_cnt});

    // Clear from S_SHOW drops the held result, keeps the count
    btn_clr = 1'b1;
    @(negedge clk);
    btn_clr = 1'b0;
    chk("clr_show_stage", {30'd0, stage}, 32'd0);
    chk("clr_show_ge", {31'd0, res_ge}, 32'd0);
    chk("clr_show_valid", {31'd0, res_valid}, 32'd0);
    chk("clr_show_cnt", {24'd0, cmp_count}, {24'd0, exp_cnt});
    @(negedge clk);

    // Held button in S_A: single load
    sw = 6'd11; btn_load = 1'b1;
    repeat (5) @(negedge clk);
    sw = 6'd22;
    repeat (15) @(negedge clk);
    chk("held_a", {26'd0, a}, 32'd11);
    chk("held_stage", {30'd0, stage}, 32'd1);
    btn_load = 1'b0;
    @(negedge clk);

    // Clear beats a coincident load edge in S_B
    sw = 6'd30; btn_load = 1'b1; btn_clr = 1'b1;
    @(negedge clk);
    btn_load = 1'b0; btn_clr = 1'b0;
    chk("clrpri_stage", {30'd0, stage}, 32'd0);
    chk("clrpri_a", {26'd0, a}, 32'd0);
    chk("clrpri_b", {26'd0, b}, 32'd0);
    chk("clrpri_valid", {31'd0, res_valid}, 32'd0);
    chk("clrpri_cnt", {24'd0, cmp_count}, {24'd0, exp_cnt});
    @(negedge clk);

    // Asynchronous reset mid-operation, observed before any clock edge
    press(6'd9);
    #1 reset = 1'b1;
    #1;
    chk("async_stage", {30'd0, stage}, 32'd0);
    chk("async_a", {26'd0, a}, 32'd0);
    chk("async_cnt", {24'd0, cmp_count}, 32'd0);
    exp_cnt = 8'd0;

    // Button held across reset release: no load
    btn_load = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_rst_stage", {30'd0, stage}, 32'd0);
    chk("held_rst_a", {26'd0, a}, 32'd0);
    btn_load = 1'b0;
    @(negedge clk);

    // Wrap: 256 comparisons return the count to 0, the 257th gives 1
    for (int i = 0; i < 256; i++) begin
      va = 6'($urandom_range(63, 0));
      vb = 6'($urandom_range(63, 0));
      eg = ($signed(va) >= $signed(vb));
      press(va);
      press(vb);
      exp_cnt = exp_cnt + 8'd1;
      chk("wrap_ge", {31'd0, res_ge}, {31'd0, eg});
    end
    chk("wrap_cnt0", {24'd0, cmp_count}, 32'd0);
    run_pair("wrap_257", 6'h10, 6'h11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
